// File: rtl/UART_bridge_pkg.sv
// Shared definitions for the UART bus-master bridge: command/reply codes,
// parser state encoding, serial frame length and the bus request payload.
package UART_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] ACK       = 8'h4B;
  localparam logic [7:0] NAK       = 8'h3F;

  // start + 8 data + stop
  localparam int unsigned BITS_PER_FRAME = 10;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ADDR,
    P_DATA,
    P_BUS,
    P_RESP
  } parser_state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrobe;
  } bus_req_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: two-flop synchroniser, falling-edge start detection,
// mid-bit sampling and stop-bit check.
// Ports: clk, reset (async, active-low), rx (serial in, idle high),
//        data (received byte), strobe (one cycle, byte valid).
module uart_byte_rx #(
  parameter int unsigned DIVISION = 867
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       strobe
);

  localparam int unsigned CNT_W = $clog2(DIVISION + 1);
  localparam int unsigned HALF  = DIVISION / 2;

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shift;

  // Receive engine; goes idle at the stop-bit sample so the next start edge is caught
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data    <= '0;
      strobe  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      strobe  <= 1'b0;
      if (!active) begin
        // detection cycle counts as cycle 0 of the start bit
        if (rx_prev && !rx_sync) begin
          active  <= 1'b1;
          cnt     <= CNT_W'(1);
          bit_idx <= '0;
        end
      end else begin
        if (cnt == CNT_W'(DIVISION)) begin
          cnt     <= '0;
          bit_idx <= bit_idx + 4'd1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        if (cnt == CNT_W'(HALF)) begin
          if (bit_idx == 4'd0) begin
            // glitch, not a real start bit
            if (rx_sync) active <= 1'b0;
          end else if (bit_idx == 4'd9) begin
            active <= 1'b0;
            if (rx_sync) begin
              data   <= shift;
              strobe <= 1'b1;
            end
          end else begin
            shift <= {rx_sync, shift[7:1]};
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART command bridge acting as a single-word bus initiator.
// Ports: clk, reset (async, active-low), rx/tx (8N1 serial, idle high),
//        bus_valid/bus_ready handshake, bus_address, bus_wstrobe, bus_wdata,
//        bus_rdata (sampled on completion), busy (frame or reply in progress).
module uart_bus_master
  import UART_bridge_pkg::*;
#(
  parameter int unsigned DIVISION     = 867,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_wstrobe,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam int unsigned CNT_W       = $clog2(DIVISION + 1);
  localparam int unsigned BIT_W       = $clog2(BITS_PER_FRAME);
  localparam int unsigned TIMEOUT_CYC = TIMEOUT_BITS * (DIVISION + 1);
  localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1);

  logic [7:0] rx_byte;
  logic       rx_strobe;

  uart_byte_rx #(.DIVISION(DIVISION)) u_rx (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .data   (rx_byte),
    .strobe (rx_strobe)
  );

  parser_state_t             state, state_n;
  logic [1:0]                byte_cnt, byte_cnt_n;
  logic                      is_write;
  bus_req_t                  req_q;
  logic [TO_W-1:0]           idle_cnt;
  logic [23:0]               resp_q;
  logic [1:0]                resp_left;
  logic [BITS_PER_FRAME-1:0] tx_shift;
  logic [BIT_W-1:0]          tx_bit;
  logic [CNT_W-1:0]          tx_cnt;
  logic                      tx_active;

  logic       addr_shift_c;
  logic       data_shift_c;
  logic       bus_done_c;
  logic       tx_load_c;
  logic [7:0] tx_byte_c;
  logic       resp_shift_c;
  logic       timeout_c;
  logic       tx_last_c;

  assign timeout_c = ((state == P_ADDR) || (state == P_DATA)) && !rx_strobe &&
                     (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign tx_last_c = tx_active && (tx_bit == BIT_W'(BITS_PER_FRAME - 1)) &&
                     (tx_cnt == CNT_W'(DIVISION));

  // Parser state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= P_IDLE;
      byte_cnt <= '0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
    end
  end

  // Parser next-state and datapath enables
  always_comb begin
    state_n      = state;
    byte_cnt_n   = byte_cnt;
    addr_shift_c = 1'b0;
    data_shift_c = 1'b0;
    bus_done_c   = 1'b0;
    tx_load_c    = 1'b0;
    tx_byte_c    = 8'h00;
    resp_shift_c = 1'b0;
    unique case (state)
      P_IDLE: begin
        byte_cnt_n = '0;
        if (rx_strobe) begin
          if ((rx_byte == CMD_WRITE) || (rx_byte == CMD_READ)) begin
            state_n = P_ADDR;
          end else begin
            state_n   = P_RESP;
            tx_load_c = 1'b1;
            tx_byte_c = NAK;
          end
        end
      end
      P_ADDR: begin
        if (timeout_c) begin
          state_n = P_IDLE;
        end else if (rx_strobe) begin
          addr_shift_c = 1'b1;
          byte_cnt_n   = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_n = is_write ? P_DATA : P_BUS;
        end
      end
      P_DATA: begin
        if (timeout_c) begin
          state_n = P_IDLE;
        end else if (rx_strobe) begin
          data_shift_c = 1'b1;
          byte_cnt_n   = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_n = P_BUS;
        end
      end
      P_BUS: begin
        if (bus_ready) begin
          bus_done_c = 1'b1;
          state_n    = P_RESP;
          tx_load_c  = 1'b1;
          tx_byte_c  = is_write ? ACK : bus_rdata[7:0];
        end
      end
      P_RESP: begin
        // chain the next reply byte directly onto the end of the stop bit
        if (tx_last_c) begin
          if (resp_left != 2'd0) begin
            tx_load_c    = 1'b1;
            tx_byte_c    = resp_q[7:0];
            resp_shift_c = 1'b1;
          end else begin
            state_n = P_IDLE;
          end
        end
      end
      default: state_n = P_IDLE;
    endcase
  end

  // Request, reply buffer, timeout counter and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_write  <= 1'b0;
      req_q     <= '0;
      idle_cnt  <= '0;
      resp_q    <= '0;
      resp_left <= '0;
      bus_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bus_valid <= (state_n == P_BUS);
      busy      <= (state_n != P_IDLE);
      if ((state == P_IDLE) && rx_strobe) is_write <= (rx_byte == CMD_WRITE);
      if (addr_shift_c) req_q.address <= {rx_byte, req_q.address[31:8]};
      if (data_shift_c) req_q.wdata <= {rx_byte, req_q.wdata[31:8]};
      if (state_n == P_BUS) req_q.wstrobe <= is_write ? 4'hF : 4'h0;
      if (rx_strobe || !((state == P_ADDR) || (state == P_DATA))) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end
      if (bus_done_c) begin
        resp_q    <= bus_rdata[31:8];
        resp_left <= is_write ? 2'd0 : 2'd3;
      end else if (resp_shift_c) begin
        resp_q    <= {8'h00, resp_q[23:8]};
        resp_left <= resp_left - 2'd1;
      end
    end
  end

  // Transmit shifter; shifting in ones leaves the line idle-high when done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift  <= '1;
      tx_bit    <= '0;
      tx_cnt    <= '0;
      tx_active <= 1'b0;
    end else if (tx_load_c) begin
      tx_shift  <= {1'b1, tx_byte_c, 1'b0};
      tx_bit    <= '0;
      tx_cnt    <= '0;
      tx_active <= 1'b1;
    end else if (tx_active) begin
      if (tx_cnt == CNT_W'(DIVISION)) begin
        tx_cnt   <= '0;
        tx_shift <= {1'b1, tx_shift[BITS_PER_FRAME-1:1]};
        if (tx_last_c) begin
          tx_active <= 1'b0;
        end else begin
          tx_bit <= tx_bit + BIT_W'(1);
        end
      end else begin
        tx_cnt <= tx_cnt + CNT_W'(1);
      end
    end
  end

  assign tx          = tx_shift[0];
  assign bus_address = req_q.address;
  assign bus_wdata   = req_q.wdata;
  assign bus_wstrobe = req_q.wstrobe;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with DIVISION=3 (4-cycle bits).
module tb_uart_bus_master;

  localparam int unsigned DIV     = 3;
  localparam int unsigned BIT_CYC = DIV + 1;

  logic        clk;
  logic        reset;
  logic        rx;
  logic        tx;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_address;
  logic [3:0]  bus_wstrobe;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // responder control (written by tests only)
  int   resp_wait;
  logic ready_tied;

  // monitor state (written by monitors only)
  logic [7:0]  tx_log [0:255];
  int          tx_n = 0;
  int          valid_cycles = 0;
  int          write_cycles = 0;
  int          txn_count = 0;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrobe;

  uart_bus_master #(.DIVISION(DIV), .TIMEOUT_BITS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .tx          (tx),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_address (bus_address),
    .bus_wstrobe (bus_wstrobe),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial receiver for the DUT tx line, sampling near each bit centre
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYC) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT_CYC) @(negedge clk);
        if (tx_n < 256) tx_log[tx_n] = b;
        tx_n++;
      end
    end
  end

  // Bus request observer
  always @(negedge clk) begin
    if (reset === 1'b1 && bus_valid === 1'b1) begin
      valid_cycles++;
      if (bus_wstrobe !== 4'h0) write_cycles++;
      cap_addr    = bus_address;
      cap_wdata   = bus_wdata;
      cap_wstrobe = bus_wstrobe;
    end
  end

  always @(posedge clk) begin
    if (reset === 1'b1 && bus_valid === 1'b1 && bus_ready === 1'b1) txn_count++;
  end

  // Responder: ready either tied high or raised after resp_wait cycles of valid
  initial begin : responder
    int wait_left;
    bus_ready = 1'b0;
    wait_left = 0;
    forever begin
      @(negedge clk);
      if (ready_tied) begin
        bus_ready = 1'b1;
      end else if (bus_valid === 1'b1) begin
        if (wait_left == 0) begin
          bus_ready = 1'b1;
        end else begin
          bus_ready = 1'b0;
          wait_left--;
        end
      end else begin
        bus_ready = 1'b0;
        wait_left = resp_wait;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (BIT_CYC) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input bit has_data);
    send_byte(cmd, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b1);
    if (has_data) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], 1'b1);
  endtask

  task automatic wait_bytes(input int n, input int max_cycles);
    for (int i = 0; i < max_cycles && tx_n < n; i++) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus_valid); end
    checks++; if (bus_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus_address); end
    checks++; if (bus_wstrobe !== 4'h0) begin errors++; $display("FAIL reset_wstrobe: got %h expected 0", bus_wstrobe); end
    checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    reset = 1'b1;
    idle(10);
  endtask

  task automatic test_write;
    int b_tx, b_val, b_txn, b_wr;
    ready_tied = 1'b1;
    b_tx = tx_n; b_val = valid_cycles; b_txn = txn_count; b_wr = write_cycles;
    send_frame(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_active: got %b expected 1", busy); end
    wait_bytes(b_tx + 1, 200);
    idle(8);
    ready_tied = 1'b0;
    checks++; if (valid_cycles - b_val !== 1) begin errors++; $display("FAIL write_valid_cycles: got %0d expected 1", valid_cycles - b_val); end
    checks++; if (txn_count - b_txn !== 1) begin errors++; $display("FAIL write_txn: got %0d expected 1", txn_count - b_txn); end
    checks++; if (write_cycles - b_wr !== 1) begin errors++; $display("FAIL write_wr_cycles: got %0d expected 1", write_cycles - b_wr); end
    checks++; if (cap_addr !== 32'h0000_0010) begin errors++; $display("FAIL write_addr: got %h expected 00000010", cap_addr); end
    checks++; if (cap_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_wdata: got %h expected deadbeef", cap_wdata); end
    checks++; if (cap_wstrobe !== 4'hF) begin errors++; $display("FAIL write_wstrobe: got %h expected f", cap_wstrobe); end
    checks++; if (tx_n - b_tx !== 1) begin errors++; $display("FAIL write_nbytes: got %0d expected 1", tx_n - b_tx); end
    checks++; if (tx_log[b_tx] !== 8'h4B) begin errors++; $display("FAIL write_ack: got %h expected 4b", tx_log[b_tx]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_done: got %b expected 0", busy); end
    idle(10);
  endtask

  task automatic test_read_wait;
    int b_tx, b_val, b_txn;
    logic [7:0] exp_b [4];
    exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
    resp_wait = 5;
    bus_rdata = 32'h1234_5678;
    b_tx = tx_n; b_val = valid_cycles; b_txn = txn_count;
    send_frame(8'h52, 32'h0000_0004, 32'h0, 1'b0);
    wait_bytes(b_tx + 4, 400);
    idle(8);
    checks++; if (valid_cycles - b_val !== 6) begin errors++; $display("FAIL read_valid_cycles: got %0d expected 6", valid_cycles - b_val); end
    checks++; if (txn_count - b_txn !== 1) begin errors++; $display("FAIL read_txn: got %0d expected 1", txn_count - b_txn); end
    checks++; if (cap_addr !== 32'h0000_0004) begin errors++; $display("FAIL read_addr: got %h expected 00000004", cap_addr); end
    checks++; if (cap_wstrobe !== 4'h0) begin errors++; $display("FAIL read_wstrobe: got %h expected 0", cap_wstrobe); end
    checks++; if (tx_n - b_tx !== 4) begin errors++; $display("FAIL read_nbytes: got %0d expected 4", tx_n - b_tx); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (tx_log[b_tx + k] !== exp_b[k]) begin errors++; $display("FAIL read_byte%0d: got %h expected %h", k, tx_log[b_tx + k], exp_b[k]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_done: got %b expected 0", busy); end
    resp_wait = 0;
    idle(10);
  endtask

  task automatic test_unknown;
    int b_tx, b_val, b_txn;
    b_tx = tx_n; b_val = valid_cycles;
    send_byte(8'h41, 1'b1);
    wait_bytes(b_tx + 1, 100);
    idle(12);
    checks++; if (tx_n - b_tx !== 1) begin errors++; $display("FAIL unk_nbytes: got %0d expected 1", tx_n - b_tx); end
    checks++; if (tx_log[b_tx] !== 8'h3F) begin errors++; $display("FAIL unk_nak: got %h expected 3f", tx_log[b_tx]); end
    checks++; if (valid_cycles - b_val !== 0) begin errors++; $display("FAIL unk_no_valid: got %0d expected 0", valid_cycles - b_val); end
    bus_rdata = 32'hA5C3_0F01;
    b_tx = tx_n; b_txn = txn_count;
    send_frame(8'h52, 32'h0000_0020, 32'h0, 1'b0);
    wait_bytes(b_tx + 4, 400);
    idle(8);
    checks++; if (txn_count - b_txn !== 1) begin errors++; $display("FAIL unk_read_txn: got %0d expected 1", txn_count - b_txn); end
    checks++; if (cap_addr !== 32'h0000_0020) begin errors++; $display("FAIL unk_read_addr: got %h expected 00000020", cap_addr); end
    checks++; if (tx_log[b_tx] !== 8'h01 || tx_log[b_tx + 3] !== 8'hA5) begin errors++; $display("FAIL unk_read_data: got %h..%h expected 01..a5", tx_log[b_tx], tx_log[b_tx + 3]); end
    idle(10);
  endtask

  task automatic test_framing;
    int b_tx, b_txn, b_wr;
    bus_rdata = 32'h0BAD_F00D;
    b_tx = tx_n; b_txn = txn_count; b_wr = write_cycles;
    send_byte(8'h57, 1'b0);
    idle(2 * BIT_CYC);
    send_frame(8'h52, 32'h0000_0030, 32'h0, 1'b0);
    wait_bytes(b_tx + 4, 400);
    idle(8);
    checks++; if (txn_count - b_txn !== 1) begin errors++; $display("FAIL frm_txn: got %0d expected 1", txn_count - b_txn); end
    checks++; if (write_cycles - b_wr !== 0) begin errors++; $display("FAIL frm_no_write: got %0d expected 0", write_cycles - b_wr); end
    checks++; if (cap_addr !== 32'h0000_0030) begin errors++; $display("FAIL frm_addr: got %h expected 00000030", cap_addr); end
    checks++; if (tx_n - b_tx !== 4) begin errors++; $display("FAIL frm_nbytes: got %0d expected 4", tx_n - b_tx); end
    checks++; if (tx_log[b_tx] !== 8'h0D || tx_log[b_tx + 1] !== 8'hF0) begin errors++; $display("FAIL frm_data: got %h %h expected 0d f0", tx_log[b_tx], tx_log[b_tx + 1]); end
    idle(10);
  endtask

  task automatic test_timeout;
    int b_tx, b_txn, b_wr;
    bus_rdata = 32'hCAFE_F00D;
    b_tx = tx_n; b_txn = txn_count; b_wr = write_cycles;
    send_byte(8'h57, 1'b1);
    send_byte(8'h01, 1'b1);
    idle(40 * BIT_CYC);
    send_frame(8'h52, 32'h0000_0040, 32'h0, 1'b0);
    wait_bytes(b_tx + 4, 400);
    idle(8);
    checks++; if (write_cycles - b_wr !== 0) begin errors++; $display("FAIL to_no_write: got %0d expected 0", write_cycles - b_wr); end
    checks++; if (txn_count - b_txn !== 1) begin errors++; $display("FAIL to_txn: got %0d expected 1", txn_count - b_txn); end
    checks++; if (cap_addr !== 32'h0000_0040) begin errors++; $display("FAIL to_addr: got %h expected 00000040", cap_addr); end
    checks++; if (tx_n - b_tx !== 4) begin errors++; $display("FAIL to_nbytes: got %0d expected 4", tx_n - b_tx); end
    checks++; if (tx_log[b_tx + 2] !== 8'hFE || tx_log[b_tx + 3] !== 8'hCA) begin errors++; $display("FAIL to_data: got %h %h expected fe ca", tx_log[b_tx + 2], tx_log[b_tx + 3]); end
    idle(10);
  endtask

  task automatic test_reset_mid;
    int b_tx;
    resp_wait = 1000;
    send_frame(8'h57, 32'h0000_0050, 32'h4433_2211, 1'b1);
    for (int i = 0; i < 100 && bus_valid !== 1'b1; i++) @(negedge clk);
    checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_valid_up: got %b expected 1", bus_valid); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    resp_wait = 0;
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus_valid); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(10);
    b_tx = tx_n;
    send_frame(8'h57, 32'h0000_0060, 32'h1234_5678, 1'b1);
    wait_bytes(b_tx + 1, 200);
    idle(8);
    checks++; if (tx_n - b_tx !== 1) begin errors++; $display("FAIL rst_mid_nbytes: got %0d expected 1", tx_n - b_tx); end
    checks++; if (tx_log[b_tx] !== 8'h4B) begin errors++; $display("FAIL rst_mid_ack: got %h expected 4b", tx_log[b_tx]); end
    checks++; if (cap_addr !== 32'h0000_0060) begin errors++; $display("FAIL rst_mid_addr: got %h expected 00000060", cap_addr); end
    checks++; if (cap_wdata !== 32'h1234_5678) begin errors++; $display("FAIL rst_mid_wdata: got %h expected 12345678", cap_wdata); end
    checks++; if (cap_wstrobe !== 4'hF) begin errors++; $display("FAIL rst_mid_wstrobe: got %h expected f", cap_wstrobe); end
  endtask

  initial begin
    reset      = 1'b0;
    rx         = 1'b1;
    bus_rdata  = 32'h0;
    resp_wait  = 0;
    ready_tied = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_unknown();
    test_framing();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
